plot_sink: RTL and testbench
============================

PLOT_SINK -- requirements
Module: plot_sink

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries (power of two, >= 2).
REQ-002 Parameter X_MAX, default 319, last valid column.
REQ-003 Parameter Y_MAX, default 239, last valid row.
REQ-004 clk  in  1  clock, all logic on rising edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 plot_in  in  1  drawing unit requests pixel write this cycle.
REQ-007 x_in  in  9  pixel column.
REQ-008 y_in  in  8  pixel row.
REQ-009 color_in  in  3  pixel colour.
REQ-010 full  out  1  FIFO holds DEPTH entries; writes this cycle are dropped.
REQ-011 vga_plot  out  1  pixel valid toward VGA adapter write port.
REQ-012 vga_x  out  9, vga_y  out  8, vga_color  out  3  pixel presented to adapter.
REQ-013 vga_ready  in  1  adapter accepts pixel this cycle.
REQ-014 clear_go  in  1  one-cycle request to fill screen with clear_color.
REQ-015 clear_color  in  3  fill colour, sampled on clear_go acceptance.
REQ-016 clear_done  out  1  one-cycle pulse when screen fill complete.
REQ-017 drop_count  out  8  count of discarded plot_in requests, saturating.

Function
REQ-018 Push occurs when plot_in=1, full=0, x_in<=X_MAX, y_in<=Y_MAX; entry {x,y,color} stored.
REQ-019 plot_in=1 with full=1 or out-of-range coordinates: not stored, drop_count +1, saturates at 255.
REQ-020 full computed from registered occupancy; a push in a cycle with full=1 is dropped even if a pop occurs the same cycle.
REQ-021 Transfer = vga_plot=1 and vga_ready=1 in the same cycle; exactly one pixel retired per transfer.
REQ-022 While vga_plot=1 and vga_ready=0, vga_x/vga_y/vga_color/vga_plot held stable.
REQ-023 FSM states: DRAIN, CLEAR.
REQ-024 DRAIN: vga_plot=1 when output register valid; output register reloads from FIFO head on transfer or when empty; pixel pushed into empty FIFO appears on vga_* the cycle after push (latency 1) and no later than 2 cycles.
REQ-025 clear_go in DRAIN sets clear_pending and latches clear_color; clear_go while pending or in CLEAR ignored.
REQ-026 DRAIN->CLEAR when clear_pending=1 and output register not stalled (invalid, or transfer this cycle); in-flight pixel completes first.
REQ-027 CLEAR: vga_plot=1, vga_color=latched colour, sweep x 0..X_MAX fastest, then y 0..Y_MAX; advance only on transfer.
REQ-028 CLEAR: FIFO still accepts pushes per REQ-018, but is not drained.
REQ-029 Transfer of (X_MAX,Y_MAX) in CLEAR: clear_done=1 next cycle for one cycle, state->DRAIN, clear_pending=0; FIFO contents then drained in push order.
REQ-030 Pixel order to adapter equals accepted push order; no pixel duplicated or lost except per REQ-019.
REQ-031 Sweep counters: x 9-bit, y 8-bit, no wrap beyond X_MAX/Y_MAX.

Reset
REQ-032 reset_n=0 at rising edge: state DRAIN, FIFO empty, full=0, vga_plot=0, vga_x=0, vga_y=0, vga_color=0, clear_done=0, drop_count=0, clear_pending=0, sweep counters 0.
REQ-033 Reset mid-CLEAR or mid-stall aborts operation; no clear_done issued; buffered pixels discarded.

Structure
REQ-034 Shared package holds X_MAX/Y_MAX defaults, coordinate/colour widths, and DRAIN/CLEAR state encoding.
REQ-035 One sub-module plot_fifo: synchronous FIFO, DEPTH x 20 bits, push/pop/full/empty, same clk/reset_n.

Verification
REQ-036 Push (10,20,3),(11,20,3) with vga_ready=1 -> vga_* shows them in order, one per cycle, vga_plot falls after.
REQ-037 vga_ready=0, push 9 pixels -> first 8 stored (plus output reg per design), full=1, excess dropped, drop_count increments per drop.
REQ-038 plot_in with x_in=320 or y_in=240 -> not output, drop_count +1; 300 drops -> drop_count=255.
REQ-039 clear_go with clear_color=5, vga_ready=1 -> 76800 pixels colour 5, raster order, clear_done single pulse after (319,239).
REQ-040 Stall vga_ready=0 while pixel valid, pulse clear_go -> pending pixel transfers first, then sweep starts at (0,0); pushes during CLEAR emerge after clear_done.
REQ-041 reset_n=0 midway through CLEAR -> all outputs 0 next cycle, no clear_done, FIFO empty.

Source files
------------

// File: rtl/plot_sink_pkg.sv
// Shared types and defaults for the plot sink: pixel layout, screen limits
// and the drain/clear state encoding.
package plot_sink_pkg;

   localparam int X_W = 9;
   localparam int Y_W = 8;
   localparam int C_W = 3;
   localparam int PIX_W = X_W + Y_W + C_W;

   localparam int X_MAX_DEFAULT = 319;
   localparam int Y_MAX_DEFAULT = 239;

   typedef enum logic {
      ST_DRAIN = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   typedef struct packed {
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
      logic [C_W-1:0] color;
   } pixel_t;

endpackage

// File: rtl/plot_fifo.sv
// Synchronous FIFO with combinational head read; pushes while full and pops
// while empty are ignored.
module plot_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 20
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign rd_data = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage is not cleared on reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/plot_sink.sv
// Buffers pixel writes from a drawing unit and streams them to a VGA adapter,
// with an interleaved full-screen fill that preserves plot order around it.
module plot_sink
   import plot_sink_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int X_MAX = X_MAX_DEFAULT,
   parameter int Y_MAX = Y_MAX_DEFAULT
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           plot_in,
   input  logic [X_W-1:0] x_in,
   input  logic [Y_W-1:0] y_in,
   input  logic [C_W-1:0] color_in,
   output logic           full,
   output logic           vga_plot,
   output logic [X_W-1:0] vga_x,
   output logic [Y_W-1:0] vga_y,
   output logic [C_W-1:0] vga_color,
   input  logic           vga_ready,
   input  logic           clear_go,
   input  logic [C_W-1:0] clear_color,
   output logic           clear_done,
   output logic [7:0]     drop_count
);

   localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX);

   state_e         state_q, state_d;
   logic           pending_q, pending_d;
   logic [C_W-1:0] ccolor_q, ccolor_d;
   logic           out_valid_q, out_valid_d;
   pixel_t         out_pix_q, out_pix_d;
   logic [X_W-1:0] sx_q, sx_d;
   logic [Y_W-1:0] sy_q, sy_d;
   logic           done_q, done_d;
   logic [7:0]     drops_q, drops_d;

   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [PIX_W-1:0] fifo_head;
   pixel_t           in_pix;
   logic             in_range, accept, transfer;

   plot_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (PIX_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (fifo_push),
      .wr_data (in_pix),
      .pop     (fifo_pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign in_pix     = '{x: x_in, y: y_in, color: color_in};
   assign in_range   = (x_in <= X_LAST) && (y_in <= Y_LAST);
   assign accept     = plot_in && !fifo_full && in_range;
   assign full       = fifo_full;
   assign clear_done = done_q;
   assign drop_count = drops_q;
   assign transfer   = vga_plot && vga_ready;

   always_comb begin
      vga_plot  = out_valid_q;
      vga_x     = out_pix_q.x;
      vga_y     = out_pix_q.y;
      vga_color = out_pix_q.color;
      if (state_q == ST_CLEAR) begin
         vga_plot  = 1'b1;
         vga_x     = sx_q;
         vga_y     = sy_q;
         vga_color = ccolor_q;
      end
   end

   // A pixel landing in an empty pipeline bypasses the FIFO straight into the
   // output register so it is visible the very next cycle.
   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      ccolor_d    = ccolor_q;
      out_valid_d = out_valid_q;
      out_pix_d   = out_pix_q;
      sx_d        = sx_q;
      sy_d        = sy_q;
      done_d      = 1'b0;
      drops_d     = drops_q;
      fifo_push   = 1'b0;
      fifo_pop    = 1'b0;

      if (plot_in && !accept && (drops_q != 8'hFF)) begin
         drops_d = drops_q + 1'b1;
      end

      case (state_q)
         ST_DRAIN: begin
            if (clear_go && !pending_q) begin
               pending_d = 1'b1;
               ccolor_d  = clear_color;
            end
            if (pending_q && (!out_valid_q || transfer)) begin
               state_d     = ST_CLEAR;
               out_valid_d = 1'b0;
               fifo_push   = accept;
            end else if (!out_valid_q || transfer) begin
               if (!fifo_empty) begin
                  fifo_pop    = 1'b1;
                  out_pix_d   = pixel_t'(fifo_head);
                  out_valid_d = 1'b1;
                  fifo_push   = accept;
               end else if (accept) begin
                  out_pix_d   = in_pix;
                  out_valid_d = 1'b1;
               end else begin
                  out_valid_d = 1'b0;
               end
            end else begin
               fifo_push = accept;
            end
         end
         ST_CLEAR: begin
            fifo_push = accept;
            if (transfer) begin
               if (sx_q == X_LAST) begin
                  sx_d = '0;
                  if (sy_q == Y_LAST) begin
                     sy_d      = '0;
                     state_d   = ST_DRAIN;
                     pending_d = 1'b0;
                     done_d    = 1'b1;
                  end else begin
                     sy_d = sy_q + 1'b1;
                  end
               end else begin
                  sx_d = sx_q + 1'b1;
               end
            end
         end
         default: state_d = ST_DRAIN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ST_DRAIN;
         pending_q   <= 1'b0;
         ccolor_q    <= '0;
         out_valid_q <= 1'b0;
         out_pix_q   <= '0;
         sx_q        <= '0;
         sy_q        <= '0;
         done_q      <= 1'b0;
         drops_q     <= '0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         ccolor_q    <= ccolor_d;
         out_valid_q <= out_valid_d;
         out_pix_q   <= out_pix_d;
         sx_q        <= sx_d;
         sy_q        <= sy_d;
         done_q      <= done_d;
         drops_q     <= drops_d;
      end
   end

endmodule

// File: tb/tb_plot_sink.sv
// Self-checking bench for plot_sink: directed vector table, corner-case
// sequences and random traffic checked against a queue-based screen model.
module tb_plot_sink;

   localparam int DEPTH = 8;
   localparam int XM    = 15;
   localparam int YM    = 23;
   localparam int NPIX  = (XM + 1) * (YM + 1);

   typedef struct packed {
      logic [8:0] x;
      logic [7:0] y;
      logic [2:0] c;
   } pix_t;

   typedef struct {
      bit p; int x; int y; int c; bit rdy;
      bit ePlot; int eX; int eY; int eC; int eDrops; bit eFull;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       plot_in = 1'b0;
   logic [8:0] x_in = '0;
   logic [7:0] y_in = '0;
   logic [2:0] color_in = '0;
   logic       vga_ready = 1'b0;
   logic       clear_go = 1'b0;
   logic [2:0] clear_color = '0;
   logic       full, vga_plot, clear_done;
   logic [8:0] vga_x;
   logic [7:0] vga_y;
   logic [2:0] vga_color;
   logic [7:0] drop_count;

   int checks = 0;
   int failures = 0;

   // Reference model: screen-level view of what the sink holds
   bit   mClear, mPending, mOutValid, mDone;
   pix_t mOut;
   pix_t mFifo[$];
   int   mSx, mSy, mDrops;
   logic [2:0] mColor;

   pix_t xferLog[$];
   int   doneCount;
   bit   seenDone;

   plot_sink #(.DEPTH(DEPTH), .X_MAX(XM), .Y_MAX(YM)) dut (
      .clk(clk), .reset_n(reset_n), .plot_in(plot_in), .x_in(x_in), .y_in(y_in),
      .color_in(color_in), .full(full), .vga_plot(vga_plot), .vga_x(vga_x),
      .vga_y(vga_y), .vga_color(vga_color), .vga_ready(vga_ready),
      .clear_go(clear_go), .clear_color(clear_color), .clear_done(clear_done),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   task automatic modelUpdate();
      bit   isFull, inRange, accept, xfer, go;
      pix_t inPix;
      if (!reset_n) begin
         mClear = 0; mPending = 0; mOutValid = 0; mDone = 0;
         mOut = '0; mFifo.delete(); mSx = 0; mSy = 0; mDrops = 0; mColor = '0;
         return;
      end
      isFull  = (mFifo.size() == DEPTH);
      inRange = (int'(x_in) <= XM) && (int'(y_in) <= YM);
      accept  = plot_in && !isFull && inRange;
      inPix   = '{x: x_in, y: y_in, c: color_in};
      if (plot_in && !accept && mDrops < 255) mDrops++;
      xfer  = (mClear || mOutValid) && vga_ready;
      mDone = 0;
      if (mClear) begin
         if (accept) mFifo.push_back(inPix);
         if (xfer) begin
            if (mSx == XM && mSy == YM) begin
               mClear = 0; mPending = 0; mDone = 1; mSx = 0; mSy = 0;
            end else if (mSx == XM) begin
               mSx = 0; mSy++;
            end else begin
               mSx++;
            end
         end
      end else begin
         go = mPending && (!mOutValid || xfer);
         if (clear_go && !mPending) begin
            mPending = 1; mColor = clear_color;
         end
         if (go) begin
            mClear = 1; mOutValid = 0;
            if (accept) mFifo.push_back(inPix);
         end else if (!mOutValid || xfer) begin
            if (mFifo.size() > 0) begin
               mOut = mFifo.pop_front(); mOutValid = 1;
               if (accept) mFifo.push_back(inPix);
            end else if (accept) begin
               mOut = inPix; mOutValid = 1;
            end else begin
               mOutValid = 0;
            end
         end else if (accept) begin
            mFifo.push_back(inPix);
         end
      end
   endtask

   task automatic checkOutput();
      bit expPlot;
      expPlot = mClear || mOutValid;
      checkVal("vga_plot", vga_plot, expPlot);
      if (expPlot) begin
         checkVal("vga_x", vga_x, mClear ? mSx : int'(mOut.x));
         checkVal("vga_y", vga_y, mClear ? mSy : int'(mOut.y));
         checkVal("vga_color", vga_color, mClear ? int'(mColor) : int'(mOut.c));
      end
      checkVal("full", full, mFifo.size() == DEPTH);
      checkVal("clear_done", clear_done, mDone);
      checkVal("drop_count", drop_count, mDrops);
   endtask

   task automatic tick();
      if (reset_n && vga_plot && vga_ready) xferLog.push_back('{x: vga_x, y: vga_y, c: vga_color});
      @(posedge clk);
      modelUpdate();
      #1;
      if (clear_done === 1'b1) begin
         doneCount++;
         seenDone = 1;
      end
      checkOutput();
   endtask

   task automatic applyStimulus(input bit p, input int x, input int y, input int c,
                                input bit rdy, input bit go, input int gc);
      plot_in     = p;
      x_in        = 9'(x);
      y_in        = 8'(y);
      color_in    = 3'(c);
      vga_ready   = rdy;
      clear_go    = go;
      clear_color = 3'(gc);
      tick();
   endtask

   task automatic checkResetState(input string tag);
      checkVal({tag, " vga_plot"}, vga_plot, 0);
      checkVal({tag, " vga_x"}, vga_x, 0);
      checkVal({tag, " vga_y"}, vga_y, 0);
      checkVal({tag, " vga_color"}, vga_color, 0);
      checkVal({tag, " full"}, full, 0);
      checkVal({tag, " clear_done"}, clear_done, 0);
      checkVal({tag, " drop_count"}, drop_count, 0);
   endtask

   task automatic runClearUntilDone(input string tag, input int budget);
      seenDone = 0;
      for (int i = 0; i < budget && !seenDone; i++) applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkVal({tag, " done seen"}, seenDone, 1);
   endtask

   initial begin
      vec_t vecs[9];
      pix_t pushed[$];
      int   mism;

      vecs[0] = '{1, 10, 20, 3, 1,  1, 10, 20, 3, 0, 0};
      vecs[1] = '{1, 11, 20, 3, 1,  1, 11, 20, 3, 0, 0};
      vecs[2] = '{0,  0,  0, 0, 1,  0,  0,  0, 0, 0, 0};
      vecs[3] = '{1, 16,  5, 1, 1,  0,  0,  0, 0, 1, 0};
      vecs[4] = '{1, 15, 24, 2, 1,  0,  0,  0, 0, 2, 0};
      vecs[5] = '{1, 15, 23, 7, 1,  1, 15, 23, 7, 2, 0};
      vecs[6] = '{0,  0,  0, 0, 0,  1, 15, 23, 7, 2, 0};
      vecs[7] = '{0,  0,  0, 0, 0,  1, 15, 23, 7, 2, 0};
      vecs[8] = '{0,  0,  0, 0, 1,  0,  0,  0, 0, 2, 0};

      reset_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 5, 5, 5, 1, 1, 3);
      checkResetState("reset");
      reset_n = 1'b1;

      // Directed vectors: two-pixel stream, range boundaries and a short stall
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].p, vecs[i].x, vecs[i].y, vecs[i].c, vecs[i].rdy, 0, 0);
         checkVal($sformatf("vec%0d plot", i), vga_plot, vecs[i].ePlot);
         if (vecs[i].ePlot) begin
            checkVal($sformatf("vec%0d x", i), vga_x, vecs[i].eX);
            checkVal($sformatf("vec%0d y", i), vga_y, vecs[i].eY);
            checkVal($sformatf("vec%0d color", i), vga_color, vecs[i].eC);
         end
         checkVal($sformatf("vec%0d drops", i), drop_count, vecs[i].eDrops);
         checkVal($sformatf("vec%0d full", i), full, vecs[i].eFull);
      end

      // Overfill while the adapter stalls: output register plus DEPTH entries survive
      xferLog.delete();
      for (int i = 0; i < 12; i++) begin
         pushed.push_back('{x: 9'(i), y: 8'(i + 1), c: 3'(i)});
         applyStimulus(1, i, i + 1, i, 0, 0, 0);
      end
      checkVal("overfill full", full, 1);
      checkVal("overfill drops", drop_count, 5);
      checkVal("overfill head x", vga_x, 0);
      for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkVal("overfill drained count", xferLog.size(), DEPTH + 1);
      mism = 0;
      for (int i = 0; i < DEPTH + 1 && i < xferLog.size(); i++) if (xferLog[i] != pushed[i]) mism++;
      checkVal("overfill order", mism, 0);
      checkVal("overfill plot after", vga_plot, 0);

      // Clear requested while a pixel is stalled; pushes during the fill come out afterwards
      xferLog.delete();
      applyStimulus(1, 3, 4, 6, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 5, 6, 1, 0, 1, 5);
      applyStimulus(1, 7, 8, 2, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkVal("stall held plot", vga_plot, 1);
      checkVal("stall held x", vga_x, 3);
      runClearUntilDone("stallclear", NPIX + 50);
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkVal("stallclear count", xferLog.size(), NPIX + 3);
      if (xferLog.size() == NPIX + 3) begin
         checkVal("stallclear first", xferLog[0], {9'd3, 8'd4, 3'd6});
         checkVal("stallclear sweep start", xferLog[1], {9'd0, 8'd0, 3'd5});
         checkVal("stallclear sweep end", xferLog[NPIX], {9'(XM), 8'(YM), 3'd5});
         checkVal("stallclear after1", xferLog[NPIX + 1], {9'd5, 8'd6, 3'd1});
         checkVal("stallclear after2", xferLog[NPIX + 2], {9'd7, 8'd8, 3'd2});
      end

      // Full-screen fill in raster order with a single done pulse
      xferLog.delete();
      doneCount = 0;
      applyStimulus(0, 0, 0, 0, 1, 1, 5);
      runClearUntilDone("fill", NPIX + 20);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkVal("fill pixel count", xferLog.size(), NPIX);
      mism = 0;
      for (int i = 0; i < xferLog.size(); i++)
         if (xferLog[i] != '{x: 9'(i % (XM + 1)), y: 8'(i / (XM + 1)), c: 3'd5}) mism++;
      checkVal("fill raster order", mism, 0);
      checkVal("fill done pulses", doneCount, 1);

      // Random traffic against the model
      for (int i = 0; i < 1500; i++) begin
         applyStimulus($urandom_range(1, 0) == 1, $urandom_range(XM + 2, 0), $urandom_range(YM + 2, 0),
                       $urandom_range(7, 0), $urandom_range(9, 0) < 7, $urandom_range(63, 0) == 0,
                       $urandom_range(7, 0));
      end
      begin
         int k = 0;
         while (k < 2000 && (mClear || mPending || mOutValid || mFifo.size() != 0)) begin
            applyStimulus(0, 0, 0, 0, 1, 0, 0);
            k++;
         end
         checkVal("random drain idle", k < 2000, 1);
      end

      // Reset in the middle of a fill aborts it silently
      applyStimulus(0, 0, 0, 0, 1, 1, 6);
      for (int i = 0; i < 60; i++) applyStimulus(i % 7 == 0, i % 10, 2, 1, 1, 0, 0);
      reset_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkResetState("midclear reset");
      reset_n = 1'b1;
      xferLog.delete();
      doneCount = 0;
      for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkVal("midclear no done", doneCount, 0);
      checkVal("midclear no pixels", xferLog.size(), 0);

      // Drop counter saturation
      for (int i = 0; i < 300; i++) applyStimulus(1, XM + 1, 0, 0, 1, 0, 0);
      checkVal("drop saturate", drop_count, 255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
